// File: rtl/gearbox_tx_66b.sv
// 66b -> DATA_W transmit gearbox: packs whole sync-header+payload blocks into a
// continuous word stream, throttling the source from the buffer fill level.
module gearbox_tx_66b #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [63:0]       in_payload,
    input  logic [1:0]        in_hdr,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              hdr_err,
    output logic              underrun,
    output logic [CNT_W-1:0]  underrun_cnt
);

    localparam int BUF_W  = DATA_W + 65;
    localparam int FILL_W = $clog2(BUF_W + 1);
    localparam logic [FILL_W-1:0] WORD_BITS  = FILL_W'(DATA_W);
    localparam logic [FILL_W-1:0] BLOCK_BITS = FILL_W'(66);

    generate
        if (DATA_W != 16 && DATA_W != 32 && DATA_W != 64) begin : g_bad_width
            $error("gearbox_tx_66b: DATA_W must be 16, 32 or 64");
        end
    endgenerate

    logic [BUF_W-1:0]  buffer_reg;
    logic [BUF_W-1:0]  buffer_next;
    logic [BUF_W-1:0]  buffer_shifted;
    logic [BUF_W-1:0]  block_ext;
    logic [FILL_W-1:0] fill_reg;
    logic [FILL_W-1:0] fill_next;
    logic [FILL_W-1:0] fill_after;
    logic              emit;
    logic              accept;
    logic              hdr_bad;

    // The shift for the outgoing word happens first; the new block lands at the
    // post-shift fill position, so it can never overlap bits still buffered.
    always_comb begin
        emit           = (fill_reg >= WORD_BITS);
        fill_after     = emit ? (fill_reg - WORD_BITS) : fill_reg;
        buffer_shifted = emit ? (buffer_reg >> DATA_W) : buffer_reg;
        accept         = in_valid && in_ready;
        block_ext      = {{(BUF_W-66){1'b0}}, in_payload, in_hdr};
        buffer_next    = buffer_shifted | (accept ? (block_ext << fill_after) : '0);
        fill_next      = fill_after + (accept ? BLOCK_BITS : '0);
        hdr_bad        = (in_hdr[1] == in_hdr[0]);
    end

    assign in_ready = (fill_after < WORD_BITS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buffer_reg   <= '0;
            fill_reg     <= '0;
            dout         <= '0;
            dout_valid   <= 1'b0;
            hdr_err      <= 1'b0;
            underrun     <= 1'b0;
            underrun_cnt <= '0;
        end else begin
            buffer_reg <= buffer_next;
            fill_reg   <= fill_next;
            hdr_err    <= accept && hdr_bad;
            dout_valid <= emit;
            underrun   <= !emit;
            if (emit) begin
                dout <= buffer_reg[DATA_W-1:0];
            end else if (underrun_cnt != '1) begin
                underrun_cnt <= underrun_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_gearbox_tx_66b.sv
// Bench for gearbox_tx_66b: a DATA_W=32 instance checked against a fill model and
// a bit-level scoreboard, plus a DATA_W=64 instance for the steady-state cadence.
module tb_gearbox_tx_66b;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [63:0] payload = '0;
    logic [1:0]  hdr     = 2'b01;
    logic        valid   = 1'b0;
    logic        ready;
    logic [31:0] dout;
    logic        dv, herr, ur;
    logic [15:0] ucnt;

    logic [63:0] p64 = '0;
    logic [1:0]  hdr64 = 2'b01;
    logic        v64 = 1'b0;
    logic        r64;
    logic [63:0] dout64;
    logic        dv64, herr64, ur64;
    logic [15:0] ucnt64;

    always #5 clk = ~clk;

    gearbox_tx_66b #(.DATA_W(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_payload(payload), .in_hdr(hdr), .in_valid(valid),
        .in_ready(ready), .dout(dout), .dout_valid(dv), .hdr_err(herr),
        .underrun(ur), .underrun_cnt(ucnt)
    );

    gearbox_tx_66b #(.DATA_W(64), .CNT_W(16)) dut64 (
        .clk(clk), .rst(rst), .in_payload(p64), .in_hdr(hdr64), .in_valid(v64),
        .in_ready(r64), .dout(dout64), .dout_valid(dv64), .hdr_err(herr64),
        .underrun(ur64), .underrun_cnt(ucnt64)
    );

    int tests = 0;
    int fails = 0;

    // Model state for the 32-bit instance; expected stream bits queued LSB first.
    int          m_fill = 0;
    logic [15:0] m_cnt  = '0;
    logic [31:0] m_last = '0;
    bit          q[$];
    bit          q64[$];
    bit          last_acc;
    bit          last_ready;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        valid = 1'b0;
        v64   = 1'b0;
        #1;
        m_fill = 0;
        m_cnt  = '0;
        m_last = '0;
        q.delete();
        q64.delete();
        chk("rst_dout_valid", dv, 0);
        chk("rst_dout", dout, 0);
        chk("rst_underrun", ur, 0);
        chk("rst_hdr_err", herr, 0);
        chk("rst_underrun_cnt", ucnt, 0);
        chk("rst_in_ready", ready, 1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One clock on the 32-bit instance; called at a falling edge.
    task automatic cycle32(input bit v, input logic [1:0] h, input logic [63:0] p);
        int          fa;
        bit          em, er, acc, eherr;
        logic [31:0] ew;
        valid = v; hdr = h; payload = p;
        #1;
        em = (m_fill >= 32);
        fa = em ? m_fill - 32 : m_fill;
        er = (fa < 32);
        chk("in_ready", ready, er);
        acc   = v && er;
        eherr = acc && (h == 2'b00 || h == 2'b11);
        if (acc) begin
            for (int i = 0; i < 2; i++) q.push_back(h[i]);
            for (int i = 0; i < 64; i++) q.push_back(p[i]);
        end
        m_fill     = fa + (acc ? 66 : 0);
        last_acc   = acc;
        last_ready = ready;
        @(posedge clk);
        @(negedge clk);
        chk("dout_valid", dv, em);
        chk("underrun", ur, !em);
        chk("hdr_err", herr, eherr);
        if (!em && m_cnt != 16'hFFFF) m_cnt++;
        chk("underrun_cnt", ucnt, m_cnt);
        if (em) begin
            if (q.size() < 32) begin
                chk("scoreboard_depth", q.size(), 32);
            end else begin
                for (int i = 0; i < 32; i++) ew[i] = q.pop_front();
                m_last = ew;
            end
        end
        chk("dout", dout, m_last);
    endtask

    typedef struct {
        bit          v;
        logic [1:0]  h;
        logic [63:0] p;
        bit          e_dv;
        logic [31:0] e_dout;
        bit          e_ur;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int n_acc, herr_cnt, ur_after, win, lows, dv_gaps, u, cnt0, budget;
        bit seen_dv;
        logic [63:0] pw;

        tbl[0] = '{1'b1, 2'b10, 64'h0123_4567_89AB_CDEF, 1'b0, 32'h0000_0000, 1'b1, 16'd1};
        tbl[1] = '{1'b0, 2'b01, 64'h0,                   1'b1, 32'h26AF_37BE, 1'b0, 16'd1};
        tbl[2] = '{1'b0, 2'b01, 64'h0,                   1'b1, 32'h048D_159E, 1'b0, 16'd1};
        tbl[3] = '{1'b0, 2'b01, 64'h0,                   1'b0, 32'h048D_159E, 1'b1, 16'd2};
        tbl[4] = '{1'b0, 2'b01, 64'h0,                   1'b0, 32'h048D_159E, 1'b1, 16'd3};

        @(negedge clk);
        do_reset();

        // Single control block after reset, then drain into underrun.
        for (int i = 0; i < 5; i++) begin
            cycle32(tbl[i].v, tbl[i].h, tbl[i].p);
            $display("[TB] vec %0d: valid=%0b dout_valid=%0b dout=%h underrun=%0b cnt=%0d",
                     i, tbl[i].v, dv, dout, ur, ucnt);
            chk("tbl_dout_valid", dv, tbl[i].e_dv);
            chk("tbl_dout", dout, tbl[i].e_dout);
            chk("tbl_underrun", ur, tbl[i].e_ur);
            chk("tbl_underrun_cnt", ucnt, tbl[i].e_cnt);
        end

        // Constant valid, bad header on the 5th accepted block.
        do_reset();
        n_acc = 0; herr_cnt = 0; ur_after = 0; win = 0; seen_dv = 0;
        for (int c = 0; c < 300; c++) begin
            pw = 64'(n_acc) * 64'h9E37_79B9_7F4A_7C15;
            cycle32(1'b1, (n_acc == 4) ? 2'b11 : 2'b01, pw);
            if (last_acc) n_acc++;
            if (herr) herr_cnt++;
            if (seen_dv && ur) ur_after++;
            if (dv) seen_dv = 1;
            if (c >= 100 && c < 166 && last_ready) win++;
        end
        $display("[TB] constant valid: %0d blocks accepted, ready %0d/66", n_acc, win);
        chk("ready_in_66", win, 32);
        chk("underrun_after_first_word", ur_after, 0);
        chk("hdr_err_pulses", herr_cnt, 1);

        // Ten idle cycles mid-stream, then resume and drain.
        u = 0; cnt0 = int'(ucnt);
        for (int c = 0; c < 10; c++) begin
            cycle32(1'b0, 2'b01, 64'h0);
            if (ur) u++;
        end
        $display("[TB] gap: %0d underrun pulses", u);
        chk("gap_cnt_delta", int'(ucnt) - cnt0, u);
        chk("gap_underruns", (u >= 7), 1);
        for (int c = 0; c < 100; c++) begin
            cycle32(1'b1, 2'b10, {$urandom, $urandom});
        end
        for (int c = 0; c < 10; c++) cycle32(1'b0, 2'b01, 64'h0);
        chk("leftover_bits", q.size(), m_fill);

        // Reset while 50 bits are buffered.
        do_reset();
        budget = 0;
        while (m_fill != 50 && budget < 200) begin
            cycle32(1'b1, 2'b01, {$urandom, $urandom});
            budget++;
        end
        chk("reach_fill_50", m_fill, 50);
        do_reset();
        cycle32(1'b1, 2'b10, 64'hFEDC_BA98_7654_3210);
        cycle32(1'b0, 2'b01, 64'h0);
        $display("[TB] after mid-stream reset: dout=%h dout_valid=%0b", dout, dv);
        chk("post_reset_valid", dv, 1);
        chk("post_reset_hdr_bit0", dout[1:0], 2'b10);

        // 64-bit instance: continuous output, one ready-low cycle in 33.
        do_reset();
        n_acc = 0; lows = 0; win = 0; dv_gaps = 0; seen_dv = 0;
        for (int c = 0; c < 1100; c++) begin
            logic [63:0] ew;
            bit acc;
            v64 = 1'b1;
            p64 = 64'h1000_0000_0000_0000 + 64'(n_acc);
            #1;
            acc = r64;
            if (c >= 10 && c < 43 && !r64) win++;
            if (c >= 10 && c < 1000 && !r64) lows++;
            if (acc) begin
                for (int i = 0; i < 2; i++) q64.push_back(hdr64[i]);
                for (int i = 0; i < 64; i++) q64.push_back(p64[i]);
                n_acc++;
            end
            @(posedge clk);
            @(negedge clk);
            if (seen_dv && !dv64) dv_gaps++;
            if (dv64) begin
                seen_dv = 1;
                if (q64.size() < 64) begin
                    chk("scoreboard64_depth", q64.size(), 64);
                end else begin
                    for (int i = 0; i < 64; i++) ew[i] = q64.pop_front();
                    if (dout64 !== ew) chk("dout64", dout64, ew);
                    else tests++;
                end
            end
        end
        $display("[TB] DATA_W=64: %0d blocks accepted, ready lows %0d in 990 cycles", n_acc, lows);
        chk("ready64_low_in_33", win, 1);
        chk("ready64_low_in_990", lows, 30);
        chk("dout64_continuous", dv_gaps, 0);
        chk("blocks64_accepted", (n_acc >= 1000), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
